// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction fetch front end feeding the IF/ID pipeline register. It keeps
// the fetch PC and issues in-order word requests to instruction memory. The
// PC of each granted request goes into a tag queue, and returned words are
// paired with their PC in a small fetch FIFO. The FIFO head is presented to
// IF/ID. A redirect flushes the FIFO, restarts fetch at the target, and
// discards every response that is still outstanding.
//
// Parameters
//   RESET_PC   first fetch address after reset
//   BUF_DEPTH  fetch FIFO entries and maximum requests in flight
//              (power of 2, >= 2)
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   if_stall        IF/ID holding; head entry is not consumed
//   redirect_valid  one-cycle pulse, restart fetch at redirect_pc
//   redirect_pc     redirect target
//   imem_req        request valid (combinational)
//   imem_addr       request word address
//   imem_gnt        request accepted this cycle
//   imem_rvalid     read data valid; responses return in request order
//   imem_rdata      instruction word
//   pc_out          PC of head entry (0 when empty)
//   ins_out         instruction of head entry (0 when empty)
//   ins_valid       head entry valid
//   ins_adel        head entry is a misaligned-fetch marker
//                   (only when IF_ALIGN_CHECK_EN is defined)
//
// Build option
//   IF_ALIGN_CHECK_EN  When this macro is defined, a redirect to a target
//                      that is not word aligned issues no request. It queues
//                      one marker entry {pc=target, ins=0, adel=1} and then
//                      halts fetch until the next redirect. When the macro is
//                      undefined, the low two target bits are cleared.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] ins_out,
    output logic        ins_valid
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic        ins_adel
`endif
);

    // Pointer width and counter width. Counters must be able to hold
    // BUF_DEPTH itself.
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [31:0]     fetch_pc_q;
    logic [CW-1:0]   inflight_q;
    logic [CW-1:0]   drop_q;

    // Tag queue: PC of every granted request, including ones later dropped.
    // Its occupancy always equals inflight_q.
    logic [31:0]     tag_pc [BUF_DEPTH];
    logic [AW-1:0]   tag_wr_q;
    logic [AW-1:0]   tag_rd_q;

    // Fetch FIFO of {pc, ins}.
    logic [31:0]     fifo_pc  [BUF_DEPTH];
    logic [31:0]     fifo_ins [BUF_DEPTH];
    logic [AW-1:0]   fifo_wr_q;
    logic [AW-1:0]   fifo_rd_q;
    logic [CW-1:0]   fifo_cnt_q;

    logic            resp_seen;
    logic            resp_keep;
    logic            resp_drop;
    logic            fire;
    logic            pop;
    logic            push;
    logic            fetch_enable;
    logic            adel_push;
    logic [31:0]     push_pc;
    logic [31:0]     push_ins;
    logic [CW-1:0]   redirect_drop;
    logic [CW:0]     occupancy;

    // -----------------------------------------------------------------------
    // Optional misaligned-redirect handling
    // -----------------------------------------------------------------------
`ifdef IF_ALIGN_CHECK_EN
    logic            fifo_adel [BUF_DEPTH];
    logic            adel_pending_q;
    logic            halted_q;
    logic [31:0]     adel_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            adel_pending_q <= 1'b0;
            halted_q       <= 1'b0;
            adel_pc_q      <= '0;
        end else if (redirect_valid) begin
            adel_pending_q <= |redirect_pc[1:0];
            halted_q       <= 1'b0;
            adel_pc_q      <= redirect_pc;
        end else if (adel_push) begin
            adel_pending_q <= 1'b0;
            halted_q       <= 1'b1;
        end
    end

    // The marker is queued only in RUN, which means every response that
    // belongs to the abandoned path has already drained.
    assign adel_push    = adel_pending_q && (state_q == ST_RUN) && !redirect_valid;
    assign fetch_enable = !adel_pending_q && !halted_q;
    assign push_pc      = adel_push ? adel_pc_q : tag_pc[tag_rd_q];
    assign push_ins     = adel_push ? 32'h0 : imem_rdata;
    assign ins_adel     = ins_valid && fifo_adel[fifo_rd_q];
`else
    assign adel_push    = 1'b0;
    assign fetch_enable = 1'b1;
    assign push_pc      = tag_pc[tag_rd_q];
    assign push_ins     = imem_rdata;
`endif

    // -----------------------------------------------------------------------
    // Datapath control
    // -----------------------------------------------------------------------
    // A response is counted only when something is outstanding. Stray
    // responses that arrive after a reset are ignored.
    assign resp_seen = imem_rvalid && (inflight_q != '0);
    assign resp_keep = resp_seen && !redirect_valid && (drop_q == '0);
    assign resp_drop = resp_seen && !redirect_valid && (drop_q != '0);

    assign ins_valid = (fifo_cnt_q != '0);
    assign pop       = ins_valid && !if_stall && !redirect_valid;
    assign push      = resp_keep || adel_push;
    assign fire      = imem_req && imem_gnt;

    // A pop in the same cycle frees a slot. This lets a new request issue
    // every cycle while the head drains, which sustains one instruction per
    // cycle when memory has single-cycle latency.
    assign occupancy = {1'b0, inflight_q} + {1'b0, fifo_cnt_q} - {{CW{1'b0}}, pop};

    // A response in the redirect cycle belongs to the old path. It retires
    // here, so it does not count towards drop.
    assign redirect_drop = inflight_q - CW'(resp_seen);

    assign imem_addr = fetch_pc_q;
    assign pc_out    = ins_valid ? fifo_pc[fifo_rd_q]  : 32'h0;
    assign ins_out   = ins_valid ? fifo_ins[fifo_rd_q] : 32'h0;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal assigned in this block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                imem_req = fetch_enable && !redirect_valid &&
                           (occupancy < {1'b0, DEPTH_C});
            end
            ST_DRAIN: begin
                if ((drop_q == '0) || (resp_seen && (drop_q == CW'(1)))) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        // A redirect has priority over everything else, including a second
        // redirect that arrives while in DRAIN.
        if (redirect_valid) begin
            state_d = (redirect_drop != '0) ? ST_DRAIN : ST_RUN;
        end
    end

    // -----------------------------------------------------------------------
    // PC, counters and pointers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            inflight_q <= inflight_q + CW'(fire) - CW'(resp_seen);
            if (fire) begin
                tag_wr_q <= tag_wr_q + AW'(1);
            end
            if (resp_seen) begin
                tag_rd_q <= tag_rd_q + AW'(1);
            end

            if (redirect_valid) begin
                fetch_pc_q <= redirect_pc & 32'hFFFF_FFFC;
                drop_q     <= redirect_drop;
                fifo_wr_q  <= '0;
                fifo_rd_q  <= '0;
                fifo_cnt_q <= '0;
            end else begin
                if (fire) begin
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                if (resp_drop) begin
                    drop_q <= drop_q - CW'(1);
                end
                if (push) begin
                    fifo_wr_q <= fifo_wr_q + AW'(1);
                end
                if (pop) begin
                    fifo_rd_q <= fifo_rd_q + AW'(1);
                end
                fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Storage arrays
    // -----------------------------------------------------------------------
    // NOTE: the storage arrays have no reset. The pointers and counts decide
    // which entries are valid, and the outputs are gated by ins_valid.
    always_ff @(posedge clk) begin
        if (fire) begin
            tag_pc[tag_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            fifo_pc[fifo_wr_q]  <= push_pc;
            fifo_ins[fifo_wr_q] <= push_ins;
`ifdef IF_ALIGN_CHECK_EN
            fifo_adel[fifo_wr_q] <= adel_push;
`endif
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed bench for if_fetch_unit. Each scenario task drives its own
// stimulus and checks outputs inline. Inputs change on the falling edge, and
// outputs are sampled 2 time units later.
//
// The memory model works as follows:
//   - imem_gnt follows gnt_en.
//   - A grant is recorded at the rising edge.
//   - The response (data = address ^ FFFFFFFF) is returned in order.
//   - The earliest return is in the next cycle, driven 1 unit after the
//     falling edge, and only while rsp_en is set.
//   - Reset clears all outstanding requests.
//
// Build option: IF_ALIGN_CHECK_EN adds the ins_adel port and its scenario.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] ins_out;
    logic        ins_valid;
`ifdef IF_ALIGN_CHECK_EN
    logic        ins_adel;
`endif

    int total = 0;
    int bad   = 0;

    bit          gnt_en = 1'b0;
    bit          rsp_en = 1'b1;
    logic [31:0] pend_q [$];

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC  (32'hBFC0_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_stall       (if_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .pc_out         (pc_out),
        .ins_out        (ins_out),
        .ins_valid      (ins_valid)
`ifdef IF_ALIGN_CHECK_EN
        ,
        .ins_adel       (ins_adel)
`endif
    );

    assign imem_gnt = gnt_en;

    // Memory model: record grants.
    always @(posedge clk) begin
        if (rst) begin
            pend_q.delete();
        end else if (imem_req && imem_gnt) begin
            pend_q.push_back(imem_addr);
        end
    end

    // Memory model: return responses in order.
    always @(negedge clk) begin
        #1;
        if (!rst && rsp_en && (pend_q.size() > 0)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_q.pop_front() ^ 32'hFFFF_FFFF;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    // Hold reset for two edges, then release at the falling edge of the BOOT
    // cycle. The next falling edge is the first RUN cycle.
    task automatic apply_reset();
        @(negedge clk);
        rst            = 1'b1;
        if_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        gnt_en         = 1'b0;
        rsp_en         = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #2;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_boot_req: got %b want 0", imem_req); end
        total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ins_valid); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc_out: got %h want 00000000", pc_out); end
        total++; if (ins_out !== 32'h0) begin bad++; $display("FAIL reset_ins_out: got %h want 00000000", ins_out); end
`ifdef IF_ALIGN_CHECK_EN
        total++; if (ins_adel !== 1'b0) begin bad++; $display("FAIL reset_adel: got %b want 0", ins_adel); end
`endif
        @(negedge clk); #2;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_run_req: got %b want 1", imem_req); end
        total++; if (imem_addr !== 32'hBFC0_0000) begin bad++; $display("FAIL reset_first_addr: got %h want bfc00000", imem_addr); end
        total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL reset_run_valid: got %b want 0", ins_valid); end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_pc;
        apply_reset();
        @(negedge clk); gnt_en = 1'b1; #2;
        total++; if (imem_addr !== 32'hBFC0_0000) begin bad++; $display("FAIL stream_addr0: got %h want bfc00000", imem_addr); end
        @(negedge clk); #2;
        total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL stream_no_bypass: got %b want 0", ins_valid); end
        total++; if (imem_addr !== 32'hBFC0_0004) begin bad++; $display("FAIL stream_addr1: got %h want bfc00004", imem_addr); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #2;
            exp_pc = 32'hBFC0_0000 + 32'(4 * i);
            total++; if (ins_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %b want 1", i, ins_valid); end
            total++; if (pc_out !== exp_pc) begin bad++; $display("FAIL stream_pc[%0d]: got %h want %h", i, pc_out, exp_pc); end
            total++; if (ins_out !== ~exp_pc) begin bad++; $display("FAIL stream_ins[%0d]: got %h want %h", i, ins_out, ~exp_pc); end
            total++; if (imem_req !== 1'b1 || imem_addr !== exp_pc + 32'd8) begin
                bad++; $display("FAIL stream_issue[%0d]: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, exp_pc + 32'd8);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        apply_reset();
        @(negedge clk); gnt_en = 1'b1; if_stall = 1'b1; #2;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL stall_req0: got %b want 1", imem_req); end
        @(negedge clk); #2;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0004) begin
            bad++; $display("FAIL stall_req1: got req=%b addr=%h want req=1 addr=bfc00004", imem_req, imem_addr);
        end
        @(negedge clk); #2;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req_limit: got %b want 0", imem_req); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            total++; if (ins_valid !== 1'b1 || pc_out !== 32'hBFC0_0000 || ins_out !== 32'h403F_FFFF) begin
                bad++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h ins=%h want v=1 pc=bfc00000 ins=403fffff", i, ins_valid, pc_out, ins_out);
            end
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_full_req[%0d]: got %b want 0", i, imem_req); end
        end
        @(negedge clk); if_stall = 1'b0; #2;
        total++; if (pc_out !== 32'hBFC0_0000 || imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0008) begin
            bad++; $display("FAIL stall_release: got pc=%h req=%b addr=%h want pc=bfc00000 req=1 addr=bfc00008", pc_out, imem_req, imem_addr);
        end
        for (int i = 1; i < 3; i++) begin
            @(negedge clk); #2;
            exp_pc = 32'hBFC0_0000 + 32'(4 * i);
            total++; if (ins_valid !== 1'b1 || pc_out !== exp_pc || ins_out !== ~exp_pc) begin
                bad++; $display("FAIL stall_after[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", i, ins_valid, pc_out, ins_out, exp_pc, ~exp_pc);
            end
        end
    endtask

    task automatic test_redirect_drain();
        apply_reset();
        @(negedge clk); gnt_en = 1'b1; rsp_en = 1'b0;
        @(negedge clk);
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h8000_1000; #2;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL redir_req_in_cycle: got %b want 0", imem_req); end
        @(negedge clk); redirect_valid = 1'b0; rsp_en = 1'b1; #2;
        for (int i = 0; i < 2; i++) begin
            total++; if (ins_valid !== 1'b0 || imem_req !== 1'b0) begin
                bad++; $display("FAIL redir_drain[%0d]: got v=%b req=%b want v=0 req=0", i, ins_valid, imem_req);
            end
            @(negedge clk); #2;
        end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_1000 || ins_valid !== 1'b0) begin
            bad++; $display("FAIL redir_target_issue: got req=%b addr=%h v=%b want req=1 addr=80001000 v=0", imem_req, imem_addr, ins_valid);
        end
        @(negedge clk); #2;
        total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL redir_pre_valid: got %b want 0", ins_valid); end
        @(negedge clk); #2;
        total++; if (ins_valid !== 1'b1 || pc_out !== 32'h8000_1000 || ins_out !== 32'h7FFF_EFFF) begin
            bad++; $display("FAIL redir_first: got v=%b pc=%h ins=%h want v=1 pc=80001000 ins=7fffefff", ins_valid, pc_out, ins_out);
        end
    endtask

    task automatic test_redirect_with_response();
        apply_reset();
        @(negedge clk); gnt_en = 1'b1;
        @(negedge clk);
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h8000_2000; if_stall = 1'b1; #2;
        total++; if (imem_req !== 1'b0 || ins_valid !== 1'b1 || pc_out !== 32'hBFC0_0000) begin
            bad++; $display("FAIL rr_cycle: got req=%b v=%b pc=%h want req=0 v=1 pc=bfc00000", imem_req, ins_valid, pc_out);
        end
        @(negedge clk); redirect_valid = 1'b0; #2;
        total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL rr_flush: got %b want 0", ins_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_2000) begin
            bad++; $display("FAIL rr_next_addr: got req=%b addr=%h want req=1 addr=80002000", imem_req, imem_addr);
        end
        @(negedge clk); #2;
        total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL rr_no_stale: got %b want 0", ins_valid); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #2;
            total++; if (ins_valid !== 1'b1 || pc_out !== 32'h8000_2000 || ins_out !== 32'h7FFF_DFFF) begin
                bad++; $display("FAIL rr_head[%0d]: got v=%b pc=%h ins=%h want v=1 pc=80002000 ins=7fffdfff", i, ins_valid, pc_out, ins_out);
            end
        end
        if_stall = 1'b0;
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        @(negedge clk); gnt_en = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b1; #2;
        total++; if (ins_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", ins_valid); end
        @(negedge clk); rst = 1'b0; #2;
        total++; if (ins_valid !== 1'b0 || pc_out !== 32'h0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL mid_after_rst: got v=%b pc=%h req=%b want v=0 pc=00000000 req=0", ins_valid, pc_out, imem_req);
        end
        @(negedge clk); gnt_en = 1'b0; #2;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0000 || ins_valid !== 1'b0) begin
            bad++; $display("FAIL mid_restart: got req=%b addr=%h v=%b want req=1 addr=bfc00000 v=0", imem_req, imem_addr, ins_valid);
        end
    endtask

`ifdef IF_ALIGN_CHECK_EN
    task automatic test_align();
        apply_reset();
        @(negedge clk); gnt_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_1002; #2;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL align_req0: got %b want 0", imem_req); end
        @(negedge clk); redirect_valid = 1'b0; #2;
        total++; if (imem_req !== 1'b0 || ins_valid !== 1'b0) begin
            bad++; $display("FAIL align_wait: got req=%b v=%b want req=0 v=0", imem_req, ins_valid);
        end
        @(negedge clk); #2;
        total++; if (ins_valid !== 1'b1 || pc_out !== 32'h8000_1002 || ins_out !== 32'h0 || ins_adel !== 1'b1) begin
            bad++; $display("FAIL align_entry: got v=%b pc=%h ins=%h adel=%b want v=1 pc=80001002 ins=00000000 adel=1", ins_valid, pc_out, ins_out, ins_adel);
        end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL align_halt_req: got %b want 0", imem_req); end
        @(negedge clk); #2;
        total++; if (ins_valid !== 1'b0 || ins_adel !== 1'b0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL align_halted: got v=%b adel=%b req=%b want v=0 adel=0 req=0", ins_valid, ins_adel, imem_req);
        end
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h8000_3000;
        @(negedge clk); redirect_valid = 1'b0; #2;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_3000) begin
            bad++; $display("FAIL align_resume: got req=%b addr=%h want req=1 addr=80003000", imem_req, imem_addr);
        end
    endtask
`else
    task automatic test_align();
        apply_reset();
        @(negedge clk); gnt_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_1002; #2;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL align_req0: got %b want 0", imem_req); end
        @(negedge clk); redirect_valid = 1'b0; #2;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_1000) begin
            bad++; $display("FAIL align_cleared: got req=%b addr=%h want req=1 addr=80001000", imem_req, imem_addr);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        if_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        test_reset();
        test_streaming();
        test_stall();
        test_redirect_drain();
        test_redirect_with_response();
        test_reset_midstream();
        test_align();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
